// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline, including the divider start/busy FSM.
// Build option: DELAY_SLOT_EN keeps the branch delay-slot instruction alive on a taken branch.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    input  logic       ex_branch_taken,
    input  logic       ex_is_div,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic       div_start,
    output logic       div_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic mem_stall;
    logic load_use;
    logic div_stall;
    logic rs_hit;
    logic rt_hit;

    assign mem_stall = mem_req & ~mem_ack;
    assign rs_hit    = id_use_rs & (id_rs == ex_dest);
    assign rt_hit    = id_use_rt & (id_rt == ex_dest);
    assign load_use  = ex_mem_read & (ex_dest != 5'd0) & (rs_hit | rt_hit);
    assign div_stall = ((state == S_IDLE) & ex_is_div) | (state == S_BUSY);

    // The divider only launches once the MEM stage is free, so EX and the divider stay in step.
    assign div_start = (state == S_IDLE) & ex_is_div & ~mem_stall;
    assign div_busy  = (state != S_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        state <= S_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    // Operands are already latched in the divider, so a memory stall does not pause the count.
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!mem_stall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path through the priority chain can infer a latch.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (div_stall) begin
            // Holding EX also holds any load-use producer, so no separate bubble is needed here.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
`ifdef DELAY_SLOT_EN
            id_ex_flush = 1'b0;
`else
            id_ex_flush = 1'b1;
`endif
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a hazard vector table plus hand-written divider and reset sequences.
module tb_pipe_hazard_ctrl;

    localparam int DIV_N = 4;

    // Output vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                 ex_mem_en, ex_mem_flush, mem_wb_flush, div_start, div_busy}
    localparam logic [9:0] E_NORM = 10'b1101010000;
    localparam logic [9:0] E_LU   = 10'b0001110000;
    localparam logic [9:0] E_MEM  = 10'b0000000100;
    localparam logic [9:0] E_DIV  = 10'b0000011000;
`ifdef DELAY_SLOT_EN
    localparam logic [9:0] E_BR   = 10'b1111010000;
`else
    localparam logic [9:0] E_BR   = 10'b1111110000;
`endif
    localparam logic [9:0] B_START = 10'b0000000010;
    localparam logic [9:0] B_BUSY  = 10'b0000000001;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, ex_is_div, mem_req, mem_ack;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_flush, mem_wb_flush, div_start, div_busy;
    logic [9:0] got;

    int n_checks;
    int n_fail;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
        .ex_is_div(ex_is_div), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .div_start(div_start), .div_busy(div_busy)
    );

    assign got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, ex_mem_flush, mem_wb_flush, div_start, div_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, dest;
        logic       use_rs, use_rt, mem_read, br, req, ack;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [9:0] actual, input logic [9:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs = '0; id_rt = '0; ex_dest = '0;
        id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
        ex_branch_taken = 0; ex_is_div = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Runs a divide from the current IDLE cycle until the stall lifts, counting stall cycles and starts.
    task automatic run_div(output int stalls, output int starts);
        stalls = 0;
        starts = 0;
        ex_is_div = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (div_start) starts++;
            if (!pc_en) stalls++;
            else break;
            next_cycle();
        end
    endtask

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic [4:0] dest,
                                logic use_rs, logic use_rt, logic mem_read, logic br,
                                logic req, logic ack, logic [9:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.dest = dest;
        v.use_rs = use_rs; v.use_rt = use_rt; v.mem_read = mem_read; v.br = br;
        v.req = req; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    initial begin
        int stalls, starts;
        n_checks = 0;
        n_fail   = 0;

        //               name            rs  rt  dst urs urt ld br req ack exp
        vecs[0]  = mk("idle",            0,  0,  0,  0,  0, 0, 0, 0, 0, E_NORM);
        vecs[1]  = mk("lu_rs",           8,  0,  8,  1,  0, 1, 0, 0, 0, E_LU);
        vecs[2]  = mk("lu_dest0",        0,  0,  0,  1,  1, 1, 0, 0, 0, E_NORM);
        vecs[3]  = mk("lu_rt",           1,  5,  5,  0,  1, 1, 0, 0, 0, E_LU);
        vecs[4]  = mk("lu_rt_unused",    1,  5,  5,  1,  0, 1, 0, 0, 0, E_NORM);
        vecs[5]  = mk("no_load",         8,  0,  8,  1,  0, 0, 0, 0, 0, E_NORM);
        vecs[6]  = mk("mem_wait",        0,  0,  0,  0,  0, 0, 0, 1, 0, E_MEM);
        vecs[7]  = mk("mem_acked",       0,  0,  0,  0,  0, 0, 0, 1, 1, E_NORM);
        vecs[8]  = mk("mem_over_lu",     8,  0,  8,  1,  0, 1, 0, 1, 0, E_MEM);
        vecs[9]  = mk("branch",          0,  0,  0,  0,  0, 0, 1, 0, 0, E_BR);
        vecs[10] = mk("branch_over_lu",  8,  0,  8,  1,  0, 1, 1, 0, 0, E_BR);
        vecs[11] = mk("mem_over_branch", 0,  0,  0,  0,  0, 0, 1, 1, 0, E_MEM);
        vecs[12] = mk("ack_no_req",      3,  3,  3,  0,  0, 1, 0, 0, 1, E_NORM);

        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("in_reset", got, E_NORM);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", got, E_NORM);

        // Combinational hazard table; the FSM stays IDLE since ex_is_div is low.
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_dest = vecs[i].dest;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            ex_mem_read = vecs[i].mem_read; ex_branch_taken = vecs[i].br;
            mem_req = vecs[i].req; mem_ack = vecs[i].ack;
            @(negedge clk);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Load-use clears after one cycle once the load moves on.
        next_cycle(); clear_inputs();
        id_rs = 8; id_use_rs = 1; ex_mem_read = 1; ex_dest = 8;
        @(negedge clk); check("lu_seq_stall", got, E_LU);
        next_cycle(); ex_mem_read = 0;
        @(negedge clk); check("lu_seq_release", got, E_NORM);

        // Memory wait for three cycles, released on the ack cycle.
        next_cycle(); clear_inputs(); mem_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check($sformatf("mem_seq_wait%0d", c), got, E_MEM);
            next_cycle();
        end
        mem_ack = 1;
        @(negedge clk); check("mem_seq_ack", got, E_NORM);

        // Divide with ex_is_div held through BUSY and DONE; a taken branch during BUSY is ignored.
        next_cycle(); clear_inputs(); ex_is_div = 1;
        @(negedge clk); check("div_start_cycle", got, E_DIV | B_START);
        for (int c = 0; c < DIV_N - 1; c++) begin
            next_cycle();
            ex_branch_taken = (c == 1);
            @(negedge clk); check($sformatf("div_busy%0d", c), got, E_DIV | B_BUSY);
        end
        next_cycle(); ex_branch_taken = 0;
        @(negedge clk); check("div_done", got, E_NORM | B_BUSY);
        next_cycle(); ex_is_div = 0;
        @(negedge clk); check("div_back_idle", got, E_NORM);

        // Memory stall blocks the launch from IDLE, then holds DONE; back-to-back divide follows.
        next_cycle(); ex_is_div = 1; mem_req = 1;
        @(negedge clk); check("div_blocked_by_mem", got, E_MEM);
        next_cycle(); mem_ack = 1;
        @(negedge clk); check("div_start_after_mem", got, E_DIV | B_START);
        for (int c = 0; c < DIV_N - 1; c++) begin
            next_cycle(); mem_ack = (c != 0);
            @(negedge clk);
            check($sformatf("div2_busy%0d", c), got, (c == 0) ? (E_MEM | B_BUSY) : (E_DIV | B_BUSY));
        end
        next_cycle(); mem_ack = 0;
        @(negedge clk); check("done_mem_hold", got, E_MEM | B_BUSY);
        next_cycle(); mem_ack = 1;
        @(negedge clk); check("done_held", got, E_NORM | B_BUSY);
        next_cycle(); mem_req = 0; mem_ack = 0;
        run_div(stalls, starts);
        check_int("b2b_stall_cycles", stalls, DIV_N);
        check_int("b2b_starts", starts, 1);
        ex_is_div = 0;
        next_cycle();
        @(negedge clk); check("b2b_idle", got, E_NORM);

        // Reset mid-BUSY at counter = 2, then a fresh full divide.
        next_cycle(); ex_is_div = 1;
        next_cycle();
        next_cycle();
        @(negedge clk); check("pre_reset_busy", got, E_DIV | B_BUSY);
        #1 rst_n = 1'b0; ex_is_div = 0;
        #1 check("reset_async_idle", got, E_NORM);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("reset_no_restart", got, E_NORM);
        next_cycle();
        run_div(stalls, starts);
        check_int("fresh_stall_cycles", stalls, DIV_N);
        check_int("fresh_starts", starts, 1);
        ex_is_div = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
